// File: rtl/fetch_pc_unit.sv
// Fetch-stage PC generator.
// Owns the architectural fetch PC presented to the I-cache, applies redirects
// from the hazard controller (bumping an epoch tag so stale fetches can be
// dropped downstream), honours IF stall/flush, and keeps saturating
// redirect/stall statistics plus a sticky redirect-misalignment flag.
module fetch_pc_unit #(
  parameter int                    ADDR_WIDTH  = 32,
  parameter logic [ADDR_WIDTH-1:0] RESET_PC    = 32'h0000_0000,
  parameter int                    EPOCH_WIDTH = 3,
  parameter int                    CNT_WIDTH   = 16
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   i2i_stall,
  input  logic                   i2i_flush,
  input  logic                   load_pc_we,
  input  logic [ADDR_WIDTH-1:0]  load_pc_new_pc,
  output logic [ADDR_WIDTH-1:0]  fetch_pc,
  output logic                   fetch_valid,
  output logic [EPOCH_WIDTH-1:0] fetch_epoch,
  output logic [CNT_WIDTH-1:0]   redirect_count,
  output logic [CNT_WIDTH-1:0]   stall_count,
  output logic                   align_err
);

  // BOOT: first cycle out of reset, RESET_PC not yet fetched.
  // RUN: live fetch. SQUASH: the cycle after a flush, fetch is dead.
  typedef enum logic [1:0] {
    ST_BOOT,
    ST_RUN,
    ST_SQUASH
  } state_t;

  state_t state;

  // PC / epoch / state / statistics update, redirect > stall > flush > advance.
  // fetch_valid is written alongside the next state so it stays a pure
  // registered decode with no combinational path from the hazard inputs.
  always_ff @(posedge clk) begin
    // NOTE: all state here uses non-blocking assignments so every register
    // samples the pre-edge values of the others, independent of statement order.
    if (rst) begin
      state          <= ST_BOOT;
      fetch_pc       <= RESET_PC;
      fetch_valid    <= 1'b0;
      fetch_epoch    <= '0;
      redirect_count <= '0;
      stall_count    <= '0;
      align_err      <= 1'b0;
    end else if (load_pc_we) begin
      // The I-cache keeps no record of a missed request, so a redirect may
      // overwrite a stalled or flushed fetch outright.
      fetch_pc    <= {load_pc_new_pc[ADDR_WIDTH-1:2], 2'b00};
      fetch_epoch <= fetch_epoch + EPOCH_WIDTH'(1);
      if (redirect_count != '1) begin
        redirect_count <= redirect_count + CNT_WIDTH'(1);
      end
      if (load_pc_new_pc[1:0] != 2'b00) begin
        align_err <= 1'b1;
      end
      state       <= ST_RUN;
      fetch_valid <= 1'b1;
    end else if (i2i_stall) begin
      // PC, epoch, state and fetch_valid all hold.
      if (stall_count != '1) begin
        stall_count <= stall_count + CNT_WIDTH'(1);
      end
    end else if (i2i_flush) begin
      // Keep the PC; the next cycle presents it as a dead fetch.
      state       <= ST_SQUASH;
      fetch_valid <= 1'b0;
    end else begin
      // Leaving BOOT keeps the PC so RESET_PC is the first live fetch;
      // RUN and SQUASH step to the next sequential word (wraps at the top).
      if (state != ST_BOOT) begin
        fetch_pc <= fetch_pc + ADDR_WIDTH'(4);
      end
      state       <= ST_RUN;
      fetch_valid <= 1'b1;
    end
  end

endmodule
